fpm_issue_ctrl: RTL and testbench

Front-end controller that sits directly upstream of the 3-state non-pipelined single-precision multiplier. It accepts operand pairs over a valid/ready handshake and resolves IEEE-754 special cases and exponent range locally. Only in-range normal operands are issued to the multiplier, with a one-cycle start pulse. The multiplier result is captured, post-checked for overflow/underflow, and presented downstream with exception flags.

---
 rtl/fpm_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fpm_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_issue_ctrl.sv
// fpm_issue_ctrl
// Front-end controller for the 3-state non-pipelined single-precision
// multiplier. It accepts one operand pair at a time over a valid/ready
// handshake and resolves NaN/Inf/zero operands and out-of-range exponent sums
// locally. It issues only in-range normal operands to the multiplier, with a
// one-cycle start pulse. The multiplier output is post-checked for
// overflow/underflow. The result is held on the output until it is accepted.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  operand pair handshake
//   in_a, in_b         IEEE-754 single operands
//   out_valid/ready    result handshake
//   out_result         IEEE-754 single product
//   out_flags          {nv, of, uf}
//   fpm_ieee1/2        operands to the multiplier (held from acceptance)
//   fpm_start          one-cycle multiplier start pulse
//   fpm_result         multiplier product (valid in CAPTURE)
module fpm_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [31:0] fpm_ieee1,
  output logic [31:0] fpm_ieee2,
  output logic        fpm_start,
  input  logic [31:0] fpm_result
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ISSUE,
    WAIT,
    CAPTURE,
    OUT
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  wait_cnt;
  logic        load_op;
  logic        load_out;
  logic [31:0] res_nxt;
  logic [2:0]  flg_nxt;
  logic        res_sign;
  logic [35:0] dec_w;
  logic [34:0] cap_w;

  // Classify both operands and resolve every case that does not need the
  // multiplier. Returns {bypass, flags[2:0], result[31:0]}; bypass=0 means
  // the pair must be issued.
  function automatic logic [35:0] decode_op(input logic [31:0] a,
                                            input logic [31:0] b);
    logic       s;
    logic       za, zb, ia, ib, na, nb;
    logic [8:0] esum;
    s    = a[31] ^ b[31];
    // exp=0 covers true zero and denormals, which are flushed to zero
    za   = (a[30:23] == 8'h00);
    zb   = (b[30:23] == 8'h00);
    ia   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    ib   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    na   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    nb   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    esum = {1'b0, a[30:23]} + {1'b0, b[30:23]};
    if (na || nb || (ia && zb) || (za && ib))
      return {1'b1, 3'b100, QNAN};
    else if (ia || ib)
      return {1'b1, 3'b000, s, 8'hFF, 23'h0};
    else if (za || zb)
      return {1'b1, 3'b000, s, 31'h0};
    // Biased sum below 127 cannot reach exponent 1; 382 and above is past 254
    // even before normalization.
    else if (esum < 9'd127)
      return {1'b1, 3'b001, s, 31'h0};
    else if (esum >= 9'd382)
      return {1'b1, 3'b010, s, 8'hFF, 23'h0};
    else
      return {1'b0, 3'b000, 32'h0};
  endfunction

  // Saturate the multiplier product: an all-ones exponent is overflow, an
  // all-zero exponent is underflow. Returns {flags[2:0], result[31:0]}.
  function automatic logic [34:0] post_check(input logic [31:0] r,
                                             input logic        s);
    if (r[30:23] == 8'hFF)
      return {3'b010, s, 8'hFF, 23'h0};
    else if (r[30:23] == 8'h00)
      return {3'b001, s, 31'h0};
    else
      return {3'b000, r};
  endfunction

  assign res_sign = fpm_ieee1[31] ^ fpm_ieee2[31];
  assign dec_w    = decode_op(fpm_ieee1, fpm_ieee2);
  assign cap_w    = post_check(fpm_result, res_sign);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fpm_start = 1'b0;
    load_op   = 1'b0;
    load_out  = 1'b0;
    res_nxt   = 32'h0;
    flg_nxt   = 3'b000;
    case (state)
      IDLE: begin
        // Held low while rst is asserted so no pair is consumed by a reset edge
        in_ready = ~rst;
        if (in_valid && !rst) begin
          load_op   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (dec_w[35]) begin
          load_out  = 1'b1;
          flg_nxt   = dec_w[34:32];
          res_nxt   = dec_w[31:0];
          state_nxt = OUT;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fpm_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'd1) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        load_out  = 1'b1;
        flg_nxt   = cap_w[34:32];
        res_nxt   = cap_w[31:0];
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, wait-counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fpm_ieee1  <= 32'h0;
      fpm_ieee2  <= 32'h0;
      out_result <= 32'h0;
      out_flags  <= 3'b000;
      wait_cnt   <= 2'd0;
    end else begin
      if (load_op) begin
        fpm_ieee1 <= in_a;
        fpm_ieee2 <= in_b;
      end
      if (state == ISSUE)
        wait_cnt <= 2'd0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 2'd1;
      if (load_out) begin
        out_result <= res_nxt;
        out_flags  <= flg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fpm_issue_ctrl.sv
// Testbench for fpm_issue_ctrl. Contains a behavioural model of the
// multiplier (samples at the end of the start cycle, writes two edges later)
// and a reference model built from the controller's classification rules.
module tb_fpm_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [31:0] fpm_ieee1;
  logic [31:0] fpm_ieee2;
  logic        fpm_start;
  logic [31:0] fpm_result;

  int n_checks;
  int n_fail;

  fpm_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .fpm_ieee1  (fpm_ieee1),
    .fpm_ieee2  (fpm_ieee2),
    .fpm_start  (fpm_start),
    .fpm_result (fpm_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply of two normal operands; saturates
  // the exponent field to all-ones or all-zeros when out of range.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  // Multiplier model
  logic [31:0] m_a, m_b;
  int          m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt      <= 0;
      fpm_result <= 32'h0;
    end else if (m_cnt == 0) begin
      if (fpm_start) begin
        m_a   <= fpm_ieee1;
        m_b   <= fpm_ieee2;
        m_cnt <= 1;
      end
    end else if (m_cnt == 1) begin
      m_cnt <= 2;
    end else begin
      fpm_result <= fmul(m_a, m_b);
      m_cnt      <= 0;
    end
  end

  // Reference: expected result, flags and whether the pair goes to the multiplier
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [2:0] f,
                                 output bit iss);
    int          ea, eb;
    bit          za, zb, ia, ib, na, nb;
    logic        s;
    logic [31:0] p;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    iss = 1'b0;
    f   = 3'b000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r = 32'h7FC00000; f = 3'b100;
    end else if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
    end else if (za || zb) begin
      r = {s, 31'h0};
    end else if (ea + eb < 127) begin
      r = {s, 31'h0}; f = 3'b001;
    end else if (ea + eb >= 382) begin
      r = {s, 8'hFF, 23'h0}; f = 3'b010;
    end else begin
      iss = 1'b1;
      p = fmul(a, b);
      if (p[30:23] == 8'hFF) begin
        r = {s, 8'hFF, 23'h0}; f = 3'b010;
      end else if (p[30:23] == 8'h00) begin
        r = {s, 31'h0}; f = 3'b001;
      end else begin
        r = p;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen_op();
    int          c;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    c = int'($urandom_range(0, 9));
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case (c)
      0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'h0; end
      1: begin e = 8'hFF; f = 23'h0; end
      2: begin e = 8'hFF; f = f | 23'h1; end
      3: e = 8'($urandom_range(190, 254));
      4: e = 8'($urandom_range(1, 70));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, f};
  endfunction

  // One complete transaction, starting and ending at a falling edge. With
  // keep=1 the next pair (na, nb) is presented right after acceptance and must
  // stay unconsumed until this result has been handed off.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] na, input logic [31:0] nb,
                        input bit keep, input int stall,
                        input bit use_const, input logic [31:0] cr,
                        input logic [2:0] cf);
    logic [31:0] er;
    logic [2:0]  ef;
    bit          iss;
    int          k, starts, guard;
    ref_op(a, b, er, ef, iss);
    if (use_const) begin
      er = cr;
      ef = cf;
    end
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    guard     = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep) begin
      in_a = na;
      in_b = nb;
    end else begin
      in_valid = 1'b0;
    end
    k      = 1;
    starts = 0;
    while (!out_valid && k < 20) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("op_a_held", fpm_ieee1, a);
      starts = starts + int'(fpm_start);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), iss ? 32'd6 : 32'd2);
    chk("start_pulses", 32'(starts), iss ? 32'd1 : 32'd0);
    chk("result", out_result, er);
    chk("flags", 32'(out_flags), 32'(ef));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_result", out_result, er);
      chk("stall_flags", 32'(out_flags), 32'(ef));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, na, nb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_fpm_start", 32'(fpm_start), 32'd0);
    chk("rst_fpm_ieee1", fpm_ieee1, 32'h0);
    chk("rst_fpm_ieee2", fpm_ieee2, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    run_op(32'h40400000, 32'h40000000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h40C00000, 3'b000);
    run_op(32'h7F800000, 32'h00000000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h7FC00000, 3'b100);
    run_op(32'hFF800000, 32'h40000000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'hFF800000, 3'b000);
    run_op(32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h7F800000, 3'b010);
    run_op(32'h7F400000, 32'h3FC00000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h7F800000, 3'b010);
    run_op(32'h00800000, 32'h00800000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h00000000, 3'b001);
    run_op(32'h80800000, 32'h00800000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h80000000, 3'b001);
    run_op(32'h00000001, 32'h7F800000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h7FC00000, 3'b100);

    // Backpressure with a second pair waiting
    run_op(32'h40400000, 32'h40000000, 32'h40400000, 32'h3FC00000, 1'b1, 5, 1'b1, 32'h40C00000, 3'b000);
    run_op(32'h40400000, 32'h3FC00000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h40900000, 3'b000);

    // Reset while waiting on the multiplier
    in_a     = 32'h40400000;
    in_b     = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_out_valid", 32'(out_valid), 32'd0);
    chk("wrst_fpm_start", 32'(fpm_start), 32'd0);
    chk("wrst_in_ready", 32'(in_ready), 32'd0);
    chk("wrst_fpm_ieee1", fpm_ieee1, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("wrst_rel_ready", 32'(in_ready), 32'd1);
    chk("wrst_rel_valid", 32'(out_valid), 32'd0);
    run_op(32'h40400000, 32'h40000000, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h40C00000, 3'b000);

    // Randomized traffic
    a = gen_op();
    b = gen_op();
    for (int n = 0; n < 300; n++) begin
      bit keep;
      na   = gen_op();
      nb   = gen_op();
      keep = 1'($urandom_range(0, 1));
      run_op(a, b, na, nb, keep, int'($urandom_range(0, 3)), 1'b0, 32'h0, 3'b000);
      a = na;
      b = nb;
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
